// File: rtl/riscv_lsu_mo_if.sv
// Handshake/bus bundle for riscv_lsu_mo: core request side, memory port side and LSU status.
// slave is the LSU's view, master is the environment (core + memory) view.
interface riscv_lsu_mo_if #(
  parameter int XLEN        = 32,
  parameter int MSIZE_WIDTH = 3
);
  logic                   core_req_valid_i;
  logic                   core_req_ready_o;
  logic                   core_we_i;
  logic [XLEN-1:0]        core_addr_i;
  logic [XLEN-1:0]        core_wdata_i;
  logic [MSIZE_WIDTH-1:0] core_msize_i;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic                   mem_we_o;
  logic [XLEN-1:0]        mem_addr_o;
  logic [XLEN/8-1:0]      mem_be_o;
  logic [XLEN-1:0]        mem_wdata_o;
  logic                   mem_rvalid_i;
  logic [XLEN-1:0]        mem_rdata_i;
  logic                   lsu_rsp_valid_o;
  logic [XLEN-1:0]        lsu_rsp_data_o;
  logic                   lsu_idle_o;
  logic                   lsu_err_o;
  logic                   lsu_misalign_o;

  modport slave (
    input  core_req_valid_i, core_we_i, core_addr_i, core_wdata_i, core_msize_i,
    input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    output core_req_ready_o, mem_req_valid_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output lsu_rsp_valid_o, lsu_rsp_data_o, lsu_idle_o, lsu_err_o, lsu_misalign_o
  );

  modport master (
    output core_req_valid_i, core_we_i, core_addr_i, core_wdata_i, core_msize_i,
    output mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    input  core_req_ready_o, mem_req_valid_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  lsu_rsp_valid_o, lsu_rsp_data_o, lsu_idle_o, lsu_err_o, lsu_misalign_o
  );
endinterface

// File: rtl/riscv_lsu_mo.sv
// Load/store unit with up to MAX_OUT in-order outstanding memory transactions.
// Define RISCV_LSU_MISALIGN_EXC_EN to block misaligned requests and pulse lsu_misalign_o.
//
// state    | meaning
// LSU_IDLE | no transactions outstanding
// LSU_LOAD | between 1 and MAX_OUT-1 transactions outstanding
// LSU_FULL | MAX_OUT transactions outstanding, new requests stall
module riscv_lsu_mo #(
  parameter int XLEN        = 32,
  parameter int MAX_OUT     = 4,
  parameter int MSIZE_WIDTH = 3
) (
  input logic           clk_i,
  input logic           arstn_i,
  riscv_lsu_mo_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int PTRW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNTW  = $clog2(MAX_OUT) + 1;
  localparam int TAGW  = 1 + OFFW + MSIZE_WIDTH;

  typedef enum logic [1:0] {LSU_IDLE, LSU_LOAD, LSU_FULL} lsu_state_t;

  lsu_state_t      state;
  logic [CNTW-1:0] count, count_nxt;
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [TAGW-1:0] tag_mem [MAX_OUT];

  logic [1:0]      size;
  logic [OFFW-1:0] offset;
  logic [3:0]      size_bytes;
  logic            full, block, ready, accept, pop;
  logic [BYTES-1:0] be;
  logic [XLEN-1:0]  wdata;

  logic [TAGW-1:0] rd_tag;
  logic            rd_we, rd_uns, sign;
  logic [OFFW-1:0] rd_off;
  logic [1:0]      rd_size;
  logic [XLEN-1:0] rd_shift, keep, ext;

  logic            rsp_valid, err;
  logic [XLEN-1:0] rsp_data;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(MAX_OUT - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign size       = bus.core_msize_i[1:0];
  assign offset     = bus.core_addr_i[OFFW-1:0];
  assign size_bytes = 4'd1 << size;
  assign full       = (count == CNTW'(MAX_OUT));

`ifdef RISCV_LSU_MISALIGN_EXC_EN
  logic misalign, presented, presented_q, misalign_q;
  // A doubleword on a 32-bit datapath can never be aligned to a single word.
  assign misalign  = ((size == 2'd3) && (XLEN == 32)) ||
                     ((bus.core_addr_i[2:0] & 3'(size_bytes - 4'd1)) != 3'd0);
  assign block     = misalign;
  assign presented = bus.core_req_valid_i & misalign;
  assign bus.lsu_misalign_o = misalign_q;
`else
  assign block = 1'b0;
  assign bus.lsu_misalign_o = 1'b0;
`endif

  assign ready  = bus.mem_req_ready_i & ~full & ~block;
  assign accept = bus.core_req_valid_i & ready;

  assign bus.core_req_ready_o = ready;
  assign bus.mem_req_valid_o  = bus.core_req_valid_i & ~full & ~block;
  assign bus.mem_we_o         = bus.core_we_i;
  assign bus.mem_addr_o       = {bus.core_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign bus.mem_be_o         = be;
  assign bus.mem_wdata_o      = wdata;

  // Lanes past the top of the word are dropped; misaligned accesses are never split.
  always_comb begin
    be = '0;
    for (int j = 0; j < BYTES; j++) begin
      if (j >= int'(offset) && j < int'(offset) + int'(size_bytes)) be[j] = 1'b1;
    end
  end

  // Element replicated across the word, then rotated so byte 0 lands on lane `offset`.
  always_comb begin
    wdata = '0;
    for (int j = 0; j < BYTES; j++) begin
      wdata[j*8 +: 8] =
        bus.core_wdata_i[((j - int'(offset)) & (int'(size_bytes) - 1) & (BYTES - 1))*8 +: 8];
    end
  end

  assign pop      = bus.mem_rvalid_i & (count != '0);
  assign rd_tag   = tag_mem[rd_ptr];
  assign rd_we    = rd_tag[TAGW-1];
  assign rd_off   = rd_tag[MSIZE_WIDTH +: OFFW];
  assign rd_size  = rd_tag[1:0];
  assign rd_uns   = rd_tag[2];
  assign rd_shift = bus.mem_rdata_i >> {rd_off, 3'b000};

  always_comb begin
    keep = '1;
    sign = rd_shift[XLEN-1];
    case (rd_size)
      2'd0: begin keep = XLEN'(8'hFF);         sign = rd_shift[7];  end
      2'd1: begin keep = XLEN'(16'hFFFF);      sign = rd_shift[15]; end
      2'd2: begin keep = XLEN'(32'hFFFF_FFFF); sign = rd_shift[31]; end
      default: ;
    endcase
    ext = (rd_shift & keep) | ((sign & ~rd_uns) ? ~keep : '0);
  end

  assign count_nxt = count + CNTW'(accept) - CNTW'(pop);

  always_ff @(posedge clk_i) begin
    if (accept) tag_mem[wr_ptr] <= {bus.core_we_i, offset, bus.core_msize_i};
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= LSU_IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_EXC_EN
      presented_q <= 1'b0;
      misalign_q  <= 1'b0;
`endif
    end else begin
      count <= count_nxt;
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      rsp_valid <= pop & ~rd_we;
      if (pop & ~rd_we) rsp_data <= ext;
      if (bus.mem_rvalid_i && count == '0) err <= 1'b1;
      if (count_nxt == '0)                   state <= LSU_IDLE;
      else if (count_nxt == CNTW'(MAX_OUT))  state <= LSU_FULL;
      else                                   state <= LSU_LOAD;
`ifdef RISCV_LSU_MISALIGN_EXC_EN
      presented_q <= presented;
      misalign_q  <= presented & ~presented_q;
`endif
    end
  end

  assign bus.lsu_rsp_valid_o = rsp_valid;
  assign bus.lsu_rsp_data_o  = rsp_data;
  assign bus.lsu_idle_o      = (state == LSU_IDLE);
  assign bus.lsu_err_o       = err;
endmodule

// File: tb/tb_riscv_lsu_mo.sv
// Self-checking bench for riscv_lsu_mo (XLEN=32, MAX_OUT=4): queue-based reference model
// compared every cycle, plus directed scenarios pinned to hand-computed values.
`timescale 1ns/1ps
module tb_riscv_lsu_mo;
  localparam int XLEN = 32, MAX_OUT = 4, MSIZE_WIDTH = 3;

  logic clk_i = 1'b0;
  logic arstn_i = 1'b0;

  riscv_lsu_mo_if #(.XLEN(XLEN), .MSIZE_WIDTH(MSIZE_WIDTH)) bus ();

  riscv_lsu_mo #(.XLEN(XLEN), .MAX_OUT(MAX_OUT), .MSIZE_WIDTH(MSIZE_WIDTH)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit we;
    int off;
    int sz;
    bit uns;
  } tag_t;

  tag_t        q[$];
  bit          m_rsp_valid;
  logic [31:0] m_rsp_data;
  bit          m_err, m_mis, m_pres;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_misaligned(input logic [31:0] addr, input int sz);
    if (sz == 3) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input int off, input int sz);
    logic [3:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) if (j >= off && j < off + (1 << sz)) b[j] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int off, input int sz,
                                         input bit uns);
    logic [31:0] v, m;
    int nb;
    v  = raw >> (off * 8);
    nb = 8 << sz;
    if (nb >= 32) return v;
    m = (32'd1 << nb) - 32'd1;
    v = v & m;
    if (!uns && v[nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    m_err = 1'b0;
    m_mis = 1'b0;
    m_pres = 1'b0;
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance the model past the edge.
  task automatic cycle(input bit v, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] ms, input bit mrdy, input bit rv, input logic [31:0] rd);
    int sz, off;
    bit mis, blk, full, e_valid, e_ready;
    logic [31:0] mask, expw;
    tag_t t;
    @(posedge clk_i);
    #1;
    bus.core_req_valid_i = v;
    bus.core_we_i        = we;
    bus.core_addr_i      = addr;
    bus.core_wdata_i     = wd;
    bus.core_msize_i     = ms;
    bus.mem_req_ready_i  = mrdy;
    bus.mem_rvalid_i     = rv;
    bus.mem_rdata_i      = rd;
    #3;
    sz   = int'(ms[1:0]);
    off  = int'(addr[1:0]);
    mis  = is_misaligned(addr, sz);
`ifdef RISCV_LSU_MISALIGN_EXC_EN
    blk  = mis;
`else
    blk  = 1'b0;
`endif
    full    = (q.size() == MAX_OUT);
    e_valid = v && !full && !blk;
    e_ready = mrdy && !full && !blk;
    check("mem_req_valid", bus.mem_req_valid_o, e_valid);
    check("core_req_ready", bus.core_req_ready_o, e_ready);
    if (e_valid) begin
      check("mem_we", bus.mem_we_o, we);
      check("mem_addr", bus.mem_addr_o, addr & ~32'd3);
      check("mem_be", bus.mem_be_o, model_be(off, sz));
      mask = '0;
      expw = '0;
      for (int j = 0; j < 4; j++) begin
        if (j >= off && j < off + (1 << sz)) begin
          mask[j*8 +: 8] = 8'hFF;
          expw[j*8 +: 8] = wd[(j - off)*8 +: 8];
        end
      end
      check("mem_wdata_lanes", bus.mem_wdata_o & mask, expw);
    end
    check("lsu_idle", bus.lsu_idle_o, q.size() == 0);
    check("lsu_rsp_valid", bus.lsu_rsp_valid_o, m_rsp_valid);
    check("lsu_rsp_data", bus.lsu_rsp_data_o, m_rsp_data);
    check("lsu_err", bus.lsu_err_o, m_err);
    check("lsu_misalign", bus.lsu_misalign_o, m_mis);

    if (rv && q.size() == 0) m_err = 1'b1;
    m_rsp_valid = 1'b0;
    if (rv && q.size() > 0) begin
      t = q.pop_front();
      if (!t.we) begin
        m_rsp_valid = 1'b1;
        m_rsp_data  = extend(rd, t.off, t.sz, t.uns);
      end
    end
    if (v && e_ready) begin
      t.we = we; t.off = off; t.sz = sz; t.uns = ms[2];
      q.push_back(t);
    end
`ifdef RISCV_LSU_MISALIGN_EXC_EN
    m_mis  = v && mis && !m_pres;
    m_pres = v && mis;
`endif
  endtask

  task automatic req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] ms);
    cycle(1'b1, we, addr, wd, ms, 1'b1, 1'b0, '0);
  endtask

  task automatic rsp(input logic [31:0] rd);
    cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1, 1'b1, rd);
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    bus.core_req_valid_i = 1'b0;
    bus.core_we_i        = 1'b0;
    bus.core_addr_i      = '0;
    bus.core_wdata_i     = '0;
    bus.core_msize_i     = '0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_rvalid_i     = 1'b0;
    bus.mem_rdata_i      = '0;
    model_clear();
    #3;
    check("reset_idle", bus.lsu_idle_o, 1'b1);
    check("reset_err", bus.lsu_err_o, 1'b0);
    check("reset_rsp_valid", bus.lsu_rsp_valid_o, 1'b0);
    check("reset_rsp_data", bus.lsu_rsp_data_o, 32'h0);
    check("reset_misalign", bus.lsu_misalign_o, 1'b0);
    #9 arstn_i = 1'b1;

    // LW 0x100, response one cycle after rvalid
    req(1'b0, 32'h100, 32'h0, 3'd2);
    check("lw_be", bus.mem_be_o, 4'hF);
    check("lw_addr", bus.mem_addr_o, 32'h100);
    rsp(32'hDEAD_BEEF);
    nop();
    check("lw_rsp_valid", bus.lsu_rsp_valid_o, 1'b1);
    check("lw_rsp_data", bus.lsu_rsp_data_o, 32'hDEAD_BEEF);
    nop();
    check("lw_rsp_pulse", bus.lsu_rsp_valid_o, 1'b0);
    check("lw_rsp_hold", bus.lsu_rsp_data_o, 32'hDEAD_BEEF);

    // LB / LBU at 0x103
    req(1'b0, 32'h103, 32'h0, 3'd0);
    rsp(32'h8011_2233);
    nop();
    check("lb_data", bus.lsu_rsp_data_o, 32'hFFFF_FF80);
    req(1'b0, 32'h103, 32'h0, 3'd4);
    rsp(32'h8011_2233);
    nop();
    check("lbu_data", bus.lsu_rsp_data_o, 32'h0000_0080);

    // SH 0x102
    req(1'b1, 32'h102, 32'h0000_ABCD, 3'd1);
    check("sh_be", bus.mem_be_o, 4'hC);
    check("sh_wdata", bus.mem_wdata_o, 32'hABCD_ABCD);
    rsp(32'h1234_5678);
    nop();
    check("sh_no_rsp", bus.lsu_rsp_valid_o, 1'b0);
    check("sh_data_hold", bus.lsu_rsp_data_o, 32'h0000_0080);

    // Fill to MAX_OUT, then release one response
    for (int i = 0; i < 4; i++) req(1'b0, 32'h200 + 32'(i * 4), 32'h0, 3'd2);
    req(1'b0, 32'h210, 32'h0, 3'd2);
    check("full_ready", bus.core_req_ready_o, 1'b0);
    check("full_valid", bus.mem_req_valid_o, 1'b0);
    check("full_not_idle", bus.lsu_idle_o, 1'b0);
    cycle(1'b1, 1'b0, 32'h210, 32'h0, 3'd2, 1'b1, 1'b1, 32'h1111_2222);
    check("full_same_cycle_pop", bus.core_req_ready_o, 1'b0);
    req(1'b0, 32'h210, 32'h0, 3'd2);
    check("full_ready_back", bus.core_req_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) rsp(32'hA5A5_0000 + 32'(i));
    nop();
    check("drained_idle", bus.lsu_idle_o, 1'b1);

    // Response with nothing outstanding, then reset with three in flight
    rsp(32'h0);
    nop();
    check("err_set", bus.lsu_err_o, 1'b1);
    nop(); nop(); nop();
    check("err_sticky", bus.lsu_err_o, 1'b1);
    for (int i = 0; i < 3; i++) req(1'b0, 32'h300 + 32'(i * 4), 32'h0, 3'd2);
    nop();
    check("pre_reset_busy", bus.lsu_idle_o, 1'b0);
    bus.core_req_valid_i = 1'b0;
    bus.mem_rvalid_i     = 1'b0;
    arstn_i = 1'b0;
    #1;
    check("async_rst_idle", bus.lsu_idle_o, 1'b1);
    check("async_rst_err", bus.lsu_err_o, 1'b0);
    model_clear();
    @(posedge clk_i);
    #2 arstn_i = 1'b1;
    rsp(32'h0);
    nop();
    check("err_after_reset", bus.lsu_err_o, 1'b1);

    // Misaligned word at 0x102
`ifdef RISCV_LSU_MISALIGN_EXC_EN
    req(1'b0, 32'h102, 32'h0, 3'd2);
    check("mis_blocked", bus.mem_req_valid_o, 1'b0);
    check("mis_not_ready", bus.core_req_ready_o, 1'b0);
    req(1'b0, 32'h102, 32'h0, 3'd2);
    check("mis_pulse", bus.lsu_misalign_o, 1'b1);
    req(1'b0, 32'h102, 32'h0, 3'd2);
    check("mis_pulse_end", bus.lsu_misalign_o, 1'b0);
    nop();
`else
    req(1'b0, 32'h102, 32'h0, 3'd2);
    check("mis_issued", bus.mem_req_valid_o, 1'b1);
    check("mis_be", bus.mem_be_o, 4'hC);
    rsp(32'hCAFE_F00D);
    nop();
    check("mis_rsp", bus.lsu_rsp_data_o, 32'h0000_CAFE);
    check("mis_flag_tied", bus.lsu_misalign_o, 1'b0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit v, rv;
      v  = ($urandom % 3) != 0;
      rv = (q.size() > 0) ? (($urandom % 3) == 0) : (($urandom % 150) == 0);
      cycle(v, 1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)),
            ($urandom % 4) != 0, rv, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/riscv_lsu_mo.md
Name: riscv_lsu_mo

Overview:
- Parametrised successor to the single-request LSU; supports up to MAX_OUT outstanding in-order memory transactions instead of one.
- Sits between the core EX/MEM stage and the data-memory port.
- Generates byte enables and write-data lanes from the access size and address.
- Tracks outstanding requests in an internal tag FIFO; sign- or zero-extends load data for writeback.

Parameters:
- XLEN, 32, data and address width in bits; must be 32 or 64.
- MAX_OUT, 4, maximum outstanding transactions; power of two, 1 to 16.
- MSIZE_WIDTH, 3, access-size code width. Bits [1:0] give log2 bytes (0=B, 1=H, 2=W, 3=D with XLEN=64 only). Bit [2] set means unsigned load.

Ports:
- clk_i  in  1  core clock
- arstn_i  in  1  asynchronous active-low reset
- core_req_valid_i  in  1  core has an access
- core_req_ready_o  out  1  LSU accepts the access this cycle
- core_we_i  in  1  1=store, 0=load
- core_addr_i  in  XLEN  byte address
- core_wdata_i  in  XLEN  store data, right-aligned
- core_msize_i  in  MSIZE_WIDTH  size/sign code
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_we_o  out  1  write enable
- mem_addr_o  out  XLEN  address aligned to XLEN/8 bytes
- mem_be_o  out  XLEN/8  byte enables
- mem_wdata_o  out  XLEN  lane-shifted store data
- mem_rvalid_i  in  1  in-order response, one per accepted request (loads and stores)
- mem_rdata_i  in  XLEN  raw read word
- lsu_rsp_valid_o  out  1  load result valid, 1-cycle pulse
- lsu_rsp_data_o  out  XLEN  extended load result
- lsu_idle_o  out  1  no outstanding transactions
- lsu_err_o  out  1  sticky: response received with FIFO empty
- lsu_misalign_o  out  1  misaligned access flagged (feature-dependent)

Behaviour:
- Reset (arstn_i low, asynchronous) clears: FIFO pointers/count, lsu_rsp_valid_o, lsu_rsp_data_o, lsu_err_o, lsu_misalign_o. lsu_idle_o reads 1; state is LSU_IDLE.
- Reset mid-operation discards all outstanding tags. Any mem_rvalid_i arriving after reset with the FIFO empty sets lsu_err_o.
- Request path is combinational; no added latency:
  - mem_req_valid_o = core_req_valid_i & !full & !block.
  - core_req_ready_o = mem_req_ready_i & !full & !block.
  - block = misalign when RISCV_LSU_MISALIGN_EXC_EN is defined, else 0.
- full = (count == MAX_OUT). It depends only on registered count; a same-cycle pop never frees a slot for a same-cycle push.
- Accept = core_req_valid_i & core_req_ready_o. On accept, push tag {we, addr[log2(XLEN/8)-1:0], msize} into the FIFO.
- Byte enables: mem_be_o = ((1 << (1 << size)) - 1) << offset, truncated to XLEN/8 bits.
- Write data: mem_wdata_o = core_wdata_i replicated and shifted by offset*8.
- Response: on mem_rvalid_i with count>0, pop the tag. If the tag is a load, then on the next clock edge:
  - lsu_rsp_valid_o <= 1;
  - lsu_rsp_data_o <= extend(mem_rdata_i >> offset*8, size, unsigned).
  Response latency is 1 cycle. Store responses pop silently.
- lsu_rsp_valid_o is low in every cycle without a load pop. lsu_rsp_data_o holds its last value.
- Simultaneous accept and response: count unchanged; push and pop pointers both advance.
- mem_rvalid_i with count==0: no pop; lsu_err_o <= 1, held until reset.
- Pointers wrap modulo MAX_OUT. count has log2(MAX_OUT)+1 bits.
- State (lsu_state_t extended with a new value LSU_FULL):
  - LSU_IDLE when count==0;
  - LSU_LOAD when 0<count<MAX_OUT;
  - LSU_FULL when count==MAX_OUT.
  - Transitions follow count after each edge. lsu_idle_o = (state==LSU_IDLE).
- misalign = (addr & ((1<<size)-1)) != 0. Size 3 with XLEN=32 counts as misaligned.

Optional Feature:
- RISCV_LSU_MISALIGN_EXC_EN defined:
  - a misaligned request is never sent to memory;
  - core_req_ready_o is held 0 while it is presented;
  - lsu_misalign_o is a registered 1-cycle pulse on the first such cycle.
  - The core must withdraw the request (trap).
- Not defined:
  - lsu_misalign_o is tied 0;
  - misaligned requests are issued with mem_be_o truncated to lanes within the word (no split).

Test Plan:
- XLEN=32, LW addr 0x100 -> mem_be_o=4'hF, mem_addr_o=0x100; rdata 0xDEADBEEF -> lsu_rsp_data_o=0xDEADBEEF one cycle after rvalid.
- LB addr 0x103, rdata 0x80112233 -> rsp 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD -> mem_be_o=4'hC, mem_wdata_o=0xABCDABCD. The store response yields no lsu_rsp_valid_o.
- MAX_OUT=4, four back-to-back loads, responses withheld -> core_req_ready_o=0 on the 5th request, state LSU_FULL. Release one rvalid -> ready returns the following cycle.
- rvalid with idle LSU -> lsu_err_o=1 and stays 1. Assert arstn_i low with 3 outstanding -> lsu_idle_o=1 and lsu_err_o=0 immediately.
- Macro defined: LW addr 0x102 -> mem_req_valid_o=0, lsu_misalign_o pulses 1 cycle. Macro undefined: same request issues with mem_be_o=4'hC.
